// File: rtl/cog_ctr_sampler_if.sv
// Cog-side bus of the phs sampler: period load, run enable, accumulator
// input, FIFO pop strobe and the FIFO/status outputs.
interface cog_ctr_sampler_if #(
    parameter int DEPTH = 4
) ();
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             setper;
    logic [31:0]      data;
    logic             run;
    logic [32:0]      phs;
    logic             rd;
    logic [31:0]      sample;
    logic             valid;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             busy;

    // The cog drives control and phs, and reads the sampled results.
    modport master (
        output setper, data, run, phs, rd,
        input  sample, valid, level, ovf, busy
    );

    // The sampler reads control and phs, and drives the results.
    modport slave (
        input  setper, data, run, phs, rd,
        output sample, valid, level, ovf, busy
    );
endinterface

// File: rtl/cog_ctr_sampler.sv
// Periodic phs sampler: every per cycles captures phs[31:0], pushes the
// modulo-2^32 difference from the previous capture into a small FIFO.
module cog_ctr_sampler #(
    parameter int PER_W = 16,
    parameter int DEPTH = 4
) (
    input  logic               clk_cog,
    input  logic               res,
    cog_ctr_sampler_if.slave   bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t           state_reg, state_next;
    logic [PER_W-1:0] per_reg, per_next;
    logic [PER_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      prev_reg, prev_next;
    logic             ovf_reg, ovf_next;
    logic [LVL_W-1:0] level_reg, level_next;

    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic [LVL_W-1:0] wr_idx;
    logic [31:0]      delta;

    // phs[32] and the upper data bits have no role in this block.
    logic unused_bits;
    assign unused_bits = ^{bus.phs, bus.data};

    assign delta   = bus.phs[31:0] - prev_reg;
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign pop     = bus.rd && (level_reg != '0);
    // When full, a simultaneous pop frees the tail slot for the new delta.
    assign push_ok = push && (!full || pop);
    assign wr_idx  = pop ? (level_reg - LVL_W'(1)) : level_reg;

    // Period/interval sequencing and capture bookkeeping.
    always_comb begin
        state_next = state_reg;
        per_next   = per_reg;
        cnt_next   = cnt_reg;
        prev_next  = prev_reg;
        ovf_next   = ovf_reg;
        push       = 1'b0;
        if (bus.setper) begin
            per_next   = bus.data[PER_W-1:0];
            ovf_next   = 1'b0;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.run && per_reg != '0) begin
                        state_next = PRIME;
                        cnt_next   = per_reg - PER_W'(1);
                    end
                end
                PRIME: begin
                    if (!bus.run) begin
                        state_next = IDLE;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - PER_W'(1);
                    end else begin
                        prev_next  = bus.phs[31:0];
                        cnt_next   = per_reg - PER_W'(1);
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state_next = IDLE;
                    end else if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - PER_W'(1);
                    end else begin
                        push      = 1'b1;
                        prev_next = bus.phs[31:0];
                        cnt_next  = per_reg - PER_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        // A push into a full FIFO with no pop is dropped and flagged.
        if (push && full && !pop) begin
            ovf_next = 1'b1;
        end
    end

    // Occupancy follows accepted pushes and pops.
    always_comb begin
        level_next = level_reg;
        if (push_ok && !pop) begin
            level_next = level_reg + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_next = level_reg - LVL_W'(1);
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            state_reg <= IDLE;
            per_reg   <= '0;
            cnt_reg   <= '0;
            prev_reg  <= '0;
            ovf_reg   <= 1'b0;
            level_reg <= '0;
        end else begin
            state_reg <= state_next;
            per_reg   <= per_next;
            cnt_reg   <= cnt_next;
            prev_reg  <= prev_next;
            ovf_reg   <= ovf_next;
            level_reg <= level_next;
        end
    end

    // Shift-register FIFO: entry 0 is the registered head. Slots beyond the
    // occupancy always hold zero, so the head reads 0 when empty.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [31:0] entry_reg, entry_next;
            logic [31:0] shifted;

            if (gi == DEPTH - 1) begin : g_last
                assign shifted = '0;
            end else begin : g_mid
                assign shifted = g_ent[gi+1].entry_reg;
            end

            // Shift on pop, then drop the new delta into the tail slot.
            always_comb begin
                entry_next = pop ? shifted : entry_reg;
                if (push_ok && wr_idx == LVL_W'(gi)) begin
                    entry_next = delta;
                end
            end

            // Entry storage.
            always_ff @(posedge clk_cog) begin
                if (res) begin
                    entry_reg <= '0;
                end else begin
                    entry_reg <= entry_next;
                end
            end
        end
    endgenerate

    assign bus.sample = g_ent[0].entry_reg;
    assign bus.valid  = (level_reg != '0);
    assign bus.level  = level_reg;
    assign bus.ovf    = ovf_reg;
    assign bus.busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_cog_ctr_sampler.sv
// Directed bench for cog_ctr_sampler: inputs change and outputs are checked
// 1 time unit after each rising clock edge.
module tb_cog_ctr_sampler;
    logic clk_cog = 1'b0;
    logic res;
    int   checks   = 0;
    int   failures = 0;
    logic [32:0] phs_step;

    always #5 clk_cog = ~clk_cog;

    cog_ctr_sampler_if #(.DEPTH(4)) bus ();

    cog_ctr_sampler #(.PER_W(16), .DEPTH(4)) dut (
        .clk_cog (clk_cog),
        .res     (res),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk_cog);
        #1;
        bus.phs = bus.phs + phs_step;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic setper(input logic [31:0] val);
        bus.setper = 1'b1;
        bus.data   = val;
        tick();
        bus.setper = 1'b0;
        bus.data   = '0;
    endtask

    initial begin
        res        = 1'b1;
        bus.setper = 1'b0;
        bus.data   = '0;
        bus.run    = 1'b0;
        bus.phs    = '0;
        bus.rd     = 1'b0;
        phs_step   = 33'd1;
        ticks(2);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_sample", bus.sample, 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        res = 1'b0;

        // Basic rate, per=4
        setper(4);
        bus.run = 1'b1;
        tick();
        chk("basic_busy", 32'(bus.busy), 1);
        ticks(4);
        chk("basic_prime_nopush", 32'(bus.valid), 0);
        ticks(3);
        chk("basic_before_push", 32'(bus.valid), 0);
        tick();
        chk("basic_push1_valid", 32'(bus.valid), 1);
        chk("basic_push1_sample", bus.sample, 4);
        chk("basic_push1_level", 32'(bus.level), 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk("basic_popped", 32'(bus.valid), 0);
        ticks(2);
        chk("basic_gap", 32'(bus.valid), 0);
        tick();
        chk("basic_push2_sample", bus.sample, 4);
        bus.run = 1'b0;
        tick();
        chk("basic_stop_busy", 32'(bus.busy), 0);
        chk("basic_stop_level", 32'(bus.level), 1);
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        chk("basic_drained", 32'(bus.level), 0);

        // Wrap-around, per=2, phs crosses 2^32 (bit 32 toggles)
        setper(2);
        bus.phs  = 33'h0_FFFF_FFF8;
        phs_step = 33'd3;
        bus.run  = 1'b1;
        ticks(4);
        chk("wrap_nopush", 32'(bus.valid), 0);
        tick();
        chk("wrap_first", bus.sample, 6);
        ticks(2);
        chk("wrap_level2", 32'(bus.level), 2);
        bus.run = 1'b0;
        tick();
        chk("wrap_head", bus.sample, 6);
        bus.rd = 1'b1;
        tick();
        chk("wrap_second", bus.sample, 6);
        chk("wrap_level1", 32'(bus.level), 1);
        tick();
        bus.rd = 1'b0;
        chk("wrap_empty_sample", bus.sample, 0);
        phs_step = 33'd1;

        // Overflow, per=1; the dropped 5th delta is 2
        setper(1);
        bus.run = 1'b1;
        ticks(5);
        chk("ovf_level3", 32'(bus.level), 3);
        phs_step = 33'd2;
        tick();
        phs_step = 33'd1;
        chk("ovf_level4", 32'(bus.level), 4);
        chk("ovf_valid", 32'(bus.valid), 1);
        chk("ovf_not_yet", 32'(bus.ovf), 0);
        tick();
        chk("ovf_set", 32'(bus.ovf), 1);
        chk("ovf_level_held", 32'(bus.level), 4);
        bus.run = 1'b0;
        tick();
        bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop", bus.sample, 1);
            tick();
        end
        bus.rd = 1'b0;
        chk("ovf_empty_valid", 32'(bus.valid), 0);
        chk("ovf_empty_sample", bus.sample, 0);
        setper(1);
        chk("ovf_cleared", 32'(bus.ovf), 0);

        // Full with simultaneous pop and push; new delta is 2
        bus.run = 1'b1;
        ticks(5);
        phs_step = 33'd2;
        tick();
        phs_step = 33'd1;
        chk("full_level", 32'(bus.level), 4);
        bus.rd = 1'b1;
        tick();
        chk("full_pp_level", 32'(bus.level), 4);
        chk("full_pp_ovf", 32'(bus.ovf), 0);
        chk("full_pp_head", bus.sample, 1);
        bus.run = 1'b0;
        tick();
        chk("full_pop1", bus.sample, 1);
        tick();
        chk("full_pop2", bus.sample, 1);
        tick();
        chk("full_new_delta", bus.sample, 2);
        chk("full_new_level", 32'(bus.level), 1);
        tick();
        bus.rd = 1'b0;
        chk("full_drained", 32'(bus.level), 0);

        // per=0 never leaves IDLE
        setper(0);
        bus.run = 1'b1;
        ticks(5);
        chk("per0_busy", 32'(bus.busy), 0);
        chk("per0_level", 32'(bus.level), 0);
        bus.run = 1'b0;

        // run dropped mid-interval, then a fresh PRIME
        setper(3);
        bus.run = 1'b1;
        ticks(7);
        chk("drop_first", bus.sample, 3);
        tick();
        bus.run = 1'b0;
        tick();
        chk("drop_busy", 32'(bus.busy), 0);
        chk("drop_kept", 32'(bus.level), 1);
        bus.run = 1'b1;
        ticks(6);
        chk("restart_no_stale", 32'(bus.level), 1);
        tick();
        chk("restart_push", 32'(bus.level), 2);
        ticks(9);
        chk("restart_full", 32'(bus.level), 4);
        chk("restart_ovf", 32'(bus.ovf), 1);
        bus.run = 1'b0;
        tick();
        bus.rd = 1'b1;
        ticks(2);
        bus.rd = 1'b0;
        chk("pre_rst_level", 32'(bus.level), 2);
        chk("pre_rst_ovf", 32'(bus.ovf), 1);

        // Reset overrides setper, rd and run
        res        = 1'b1;
        bus.setper = 1'b1;
        bus.data   = 32'd5;
        bus.rd     = 1'b1;
        bus.run    = 1'b1;
        tick();
        chk("mrst_level", 32'(bus.level), 0);
        chk("mrst_valid", 32'(bus.valid), 0);
        chk("mrst_sample", bus.sample, 0);
        chk("mrst_ovf", 32'(bus.ovf), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        res        = 1'b0;
        bus.setper = 1'b0;
        bus.rd     = 1'b0;
        ticks(2);
        chk("mrst_per_zero", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
